core_msg_arbiter: RTL and testbench

//  Collects the core_msg_data/core_msg_valid pulse streams from CORE_COUNT riscv_axi_wrapper cores.

---
 rtl/core_msg_arbiter.sv | 112 +++++++++++
 tb/tb_core_msg_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/core_msg_arbiter.sv
// core_msg_arbiter: per-core message FIFOs drained round-robin onto one tagged valid/ready stream
module core_msg_arbiter #(
    parameter int CORE_COUNT     = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int FIFO_DEPTH     = 4,
    parameter int CORE_ID_WIDTH  = 2,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [CORE_COUNT*DATA_WIDTH-1:0]     core_msg_data,
    input  logic [CORE_COUNT-1:0]                core_msg_valid,
    output logic [DATA_WIDTH-1:0]                m_msg_data,
    output logic [CORE_ID_WIDTH-1:0]             m_msg_core,
    output logic                                 m_msg_valid,
    input  logic                                 m_msg_ready,
    output logic [CORE_COUNT-1:0]                fifo_full,
    output logic [CORE_COUNT*DROP_CNT_WIDTH-1:0] drop_count,
    input  logic                                 drop_clear
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0]     mem_q [CORE_COUNT][FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr_q [CORE_COUNT];
    logic [PW-1:0]             wr_ptr_d [CORE_COUNT];
    logic [PW-1:0]             rd_ptr_q [CORE_COUNT];
    logic [PW-1:0]             rd_ptr_d [CORE_COUNT];
    logic [DROP_CNT_WIDTH-1:0] drop_q [CORE_COUNT];
    logic [DROP_CNT_WIDTH-1:0] drop_d [CORE_COUNT];
    logic [CORE_COUNT-1:0]     fifo_full_q, fifo_full_d;
    logic [CORE_COUNT-1:0]     not_empty, is_full, push, pop;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [CORE_ID_WIDTH-1:0]  core_q, core_d, ptr_q, ptr_d, gnt;
    logic                      valid_q, valid_d, found, load;

    always_comb begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            not_empty[i] = wr_ptr_q[i] != rd_ptr_q[i];
            is_full[i]   = PW'(wr_ptr_q[i] - rd_ptr_q[i]) == PW'(FIFO_DEPTH);
        end
    end

    always_comb begin
        found = 1'b0;
        gnt   = ptr_q;
        for (int k = 1; k <= CORE_COUNT; k++) begin
            if (!found && not_empty[(int'(ptr_q) + k) % CORE_COUNT]) begin
                found = 1'b1;
                gnt   = CORE_ID_WIDTH'((int'(ptr_q) + k) % CORE_COUNT);
            end
        end
    end

    always_comb begin
        load    = (!valid_q || m_msg_ready) && found;
        valid_d = load || (valid_q && !m_msg_ready);
        data_d  = load ? mem_q[gnt][rd_ptr_q[gnt][AW-1:0]] : data_q;
        core_d  = load ? gnt : core_q;
        ptr_d   = load ? gnt : ptr_q;
        for (int i = 0; i < CORE_COUNT; i++) begin
            push[i]        = core_msg_valid[i] && !is_full[i];
            pop[i]         = load && gnt == CORE_ID_WIDTH'(i);
            wr_ptr_d[i]    = wr_ptr_q[i] + PW'(push[i]);
            rd_ptr_d[i]    = rd_ptr_q[i] + PW'(pop[i]);
            fifo_full_d[i] = PW'(wr_ptr_d[i] - rd_ptr_d[i]) == PW'(FIFO_DEPTH);
            drop_d[i]      = drop_clear ? '0 : drop_q[i];
            drop_d[i]      = drop_d[i] + DROP_CNT_WIDTH'(core_msg_valid[i] && is_full[i] && !(&drop_d[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                drop_q[i]   <= '0;
            end
            fifo_full_q <= '0;
            data_q      <= '0;
            core_q      <= '0;
            valid_q     <= 1'b0;
            ptr_q       <= CORE_ID_WIDTH'(CORE_COUNT - 1);
        end else begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                drop_q[i]   <= drop_d[i];
            end
            fifo_full_q <= fifo_full_d;
            data_q      <= data_d;
            core_q      <= core_d;
            valid_q     <= valid_d;
            ptr_q       <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= core_msg_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        for (int i = 0; i < CORE_COUNT; i++) drop_count[i*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_q[i];
    end

    assign m_msg_data  = data_q;
    assign m_msg_core  = core_q;
    assign m_msg_valid = valid_q;
    assign fifo_full   = fifo_full_q;
endmodule

// File: tb/tb_core_msg_arbiter.sv
// tb_core_msg_arbiter: directed checks of queuing, round-robin, back-pressure, overflow, saturation and reset
module tb_core_msg_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] core_msg_data = '0;
    logic [3:0]   core_msg_valid = '0;
    logic [63:0]  m_msg_data;
    logic [1:0]   m_msg_core;
    logic         m_msg_valid;
    logic         m_msg_ready = 1'b1;
    logic [3:0]   fifo_full;
    logic [63:0]  drop_count;
    logic         drop_clear = 1'b0;
    int           n_tests = 0;
    int           n_fail = 0;

    core_msg_arbiter dut (
        .clk(clk), .rst_n(rst_n), .core_msg_data(core_msg_data), .core_msg_valid(core_msg_valid),
        .m_msg_data(m_msg_data), .m_msg_core(m_msg_core), .m_msg_valid(m_msg_valid),
        .m_msg_ready(m_msg_ready), .fifo_full(fifo_full), .drop_count(drop_count), .drop_clear(drop_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        core_msg_valid = '0;
        drop_clear = 1'b0;
        m_msg_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        check("rst_valid", m_msg_valid, 0);
        check("rst_data", m_msg_data, 0);
        check("rst_core", m_msg_core, 0);
        check("rst_full", fifo_full, 0);
        check("rst_drop", drop_count, 0);

        // single message from core 2
        core_msg_data[128 +: 64] = 64'hDEAD_BEEF_0000_0002;
        core_msg_valid = 4'b0100;
        tick();
        core_msg_valid = '0;
        check("t1_not_yet", m_msg_valid, 0);
        tick();
        check("t1_valid", m_msg_valid, 1);
        check("t1_core", m_msg_core, 2);
        check("t1_data", m_msg_data, 64'hDEAD_BEEF_0000_0002);
        tick();
        check("t1_one_cycle", m_msg_valid, 0);

        // round-robin, two simultaneous bursts
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) core_msg_data[i*64 +: 64] = 64'h100 * (b + 1) + 64'(i);
            core_msg_valid = 4'hF;
            tick();
            core_msg_valid = '0;
            for (int i = 0; i < 4; i++) begin
                tick();
                check("rr_valid", m_msg_valid, 1);
                check("rr_core", m_msg_core, 64'(i));
                check("rr_data", m_msg_data, 64'h100 * (b + 1) + 64'(i));
            end
            tick();
            check("rr_drained", m_msg_valid, 0);
        end

        // back-pressure: three messages from core 1 with ready low
        m_msg_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            core_msg_data[64 +: 64] = 64'h300 + 64'(k);
            core_msg_valid = 4'b0010;
            tick();
        end
        core_msg_valid = '0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("bp_hold_valid", m_msg_valid, 1);
            check("bp_hold_data", m_msg_data, 64'h300);
        end
        check("bp_hold_core", m_msg_core, 1);
        m_msg_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            check("bp_drain_valid", m_msg_valid, 1);
            check("bp_drain_data", m_msg_data, 64'h300 + 64'(k));
        end
        tick();
        check("bp_done", m_msg_valid, 0);

        // overflow on core 0: slot + 4 queued, 6th and 7th strobes dropped
        do_reset();
        m_msg_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            core_msg_data[0 +: 64] = 64'h400 + 64'(k);
            core_msg_valid = 4'b0001;
            tick();
        end
        core_msg_valid = '0;
        check("ov_full", fifo_full, 4'b0001);
        check("ov_drop1", drop_count[15:0], 1);
        core_msg_data[0 +: 64] = 64'h406;
        core_msg_valid = 4'b0001;
        tick();
        core_msg_valid = '0;
        check("ov_drop2", drop_count[15:0], 2);
        check("ov_others", drop_count[63:16], 0);
        m_msg_ready = 1'b1;
        check("ov_slot", m_msg_data, 64'h400);
        for (int k = 1; k < 5; k++) begin
            tick();
            check("ov_drain", m_msg_data, 64'h400 + 64'(k));
        end
        check("ov_not_full", fifo_full, 0);
        tick();
        check("ov_empty", m_msg_valid, 0);

        // saturation then clear together with a drop on core 3
        do_reset();
        m_msg_ready = 1'b0;
        core_msg_data[192 +: 64] = 64'h500;
        core_msg_valid = 4'b1000;
        for (int k = 0; k < 70010; k++) tick();
        check("sat_max", drop_count[63:48], 16'hFFFF);
        drop_clear = 1'b1;
        tick();
        drop_clear = 1'b0;
        core_msg_valid = '0;
        check("clr_drop", drop_count[63:48], 1);
        check("clr_others", drop_count[47:0], 0);

        // asynchronous reset in the middle of traffic
        do_reset();
        m_msg_ready = 1'b0;
        core_msg_data[0 +: 64] = 64'h600;
        core_msg_data[128 +: 64] = 64'h602;
        core_msg_valid = 4'b0101;
        for (int k = 0; k < 3; k++) tick();
        core_msg_valid = '0;
        check("mid_valid", m_msg_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", m_msg_valid, 0);
        check("arst_data", m_msg_data, 0);
        check("arst_core", m_msg_core, 0);
        tick();
        rst_n = 1'b1;
        m_msg_ready = 1'b1;
        tick();
        core_msg_data[64 +: 64] = 64'h701;
        core_msg_valid = 4'b0010;
        tick();
        core_msg_valid = '0;
        tick();
        check("post_valid", m_msg_valid, 1);
        check("post_core", m_msg_core, 1);
        check("post_data", m_msg_data, 64'h701);
        tick();
        check("post_alone", m_msg_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
